ifu_fetch_queue: RTL and testbench
==================================

Name: ifu_fetch_queue

Overview:
- Decoupling buffer between the ICache/fetch-group output of the IFU and the decode stage.
- Stores whole fetch groups: one PC, INSTR_PER_FETCH instruction slots, a per-slot valid mask and the branch prediction.
- Delivers one group per cycle to decode over a valid/ready handshake.
- Frontend flushes from redirects clear the whole queue.

Parameters:
- DEPTH, 8: number of fetch-group entries. Power of two, ≥2; an elaboration assertion enforces this.
- INSTR_PER_FETCH, 4: instruction slots per group.
- ILEN, 32: instruction width in bits.
- XLEN, 32: PC/target width in bits.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  drop all contents (redirect/mispredict).
- enq_valid_i  in  1  fetch group offered.
- enq_ready_o  out  1  queue can accept a group.
- enq_pc_i  in  XLEN  PC of slot 0.
- enq_instr_i  in  INSTR_PER_FETCH*ILEN  instructions; slot i at bits [i*ILEN +: ILEN].
- enq_mask_i  in  INSTR_PER_FETCH  per-slot valid.
- enq_pred_taken_i  in  1  BPU predicted taken.
- enq_pred_target_i  in  XLEN  BPU predicted target.
- deq_valid_o  out  1  head group available.
- deq_ready_i  in  1  decode accepts head.
- deq_pc_o  out  XLEN  head PC.
- deq_instr_o  out  INSTR_PER_FETCH*ILEN  head instructions.
- deq_mask_o  out  INSTR_PER_FETCH  head slot mask.
- deq_pred_taken_o  out  1  head prediction.
- deq_pred_target_o  out  XLEN  head target.
- count_o  out  $clog2(DEPTH+1)  occupied entries.

Behaviour:
- Reset (async assert, sync release):
  - Pointers and count = 0.
  - deq_valid_o = 0, enq_ready_o = 1, count_o = 0.
  - All deq data outputs = 0.
  - Storage array is not reset. Data outputs are gated to 0 whenever deq_valid_o = 0.
- Storage and pointers:
  - Circular buffer with rd_ptr and wr_ptr, each log2(DEPTH) bits, wrapping naturally.
  - count register of $clog2(DEPTH+1) bits.
  - full = (count == DEPTH); empty = (count == 0).
- enq_ready_o:
  - Equals !full, from registered state only. There is no combinational path from deq_ready_i.
  - Enqueue while full is not accepted, even if a dequeue happens in the same cycle.
- Handshakes:
  - enq fires = enq_valid_i & enq_ready_o & !flush_i.
  - deq fires = deq_valid_o & deq_ready_i.
- Zero-mask groups: if enq fires with enq_mask_i == 0, the group is consumed (handshake completes) but not written; pointers and count are unchanged.
- Dequeue output: deq_valid_o = !empty & !flush_i. deq_* outputs show mem[rd_ptr] combinationally.
- Latency: an enqueued group is visible at deq the cycle after acceptance (1 cycle).
- Simultaneous enq + deq (non-full, non-empty): write at wr_ptr, read at rd_ptr, count unchanged, both pointers advance.
- Empty + enq: count becomes 1 next cycle; deq_valid_o stays 0 this cycle (without the optional bypass).
- flush_i:
  - Has priority over everything.
  - Next cycle: rd_ptr = wr_ptr = 0, count = 0.
  - The enqueue offered in the flush cycle is discarded.
  - deq_valid_o = 0 during the flush cycle, so no dequeue fires.
- Reset mid-operation: all contents lost immediately; outputs return to reset values asynchronously.
- Group contents are never reordered or split; deq_mask_o equals the mask as enqueued.

Optional Feature:
- Macro: IFU_FETCHQ_BYPASS_EN.
- Defined: when empty, !flush_i, enq_valid_i = 1 and enq_mask_i != 0:
  - deq_valid_o = 1 and deq_* are driven straight from enq_* in the same cycle.
  - If deq_ready_i = 1, the group passes through without being written: count stays 0 and pointers do not move.
  - If deq_ready_i = 0, the group is written normally (count = 1 next cycle).
- Undefined: no enq→deq combinational path; minimum latency is 1 cycle.

Test Plan:
- Reset, then enq pc=0x8000_0000, mask=4'b1111, deq_ready_i=1 → next cycle deq_valid_o=1, deq_pc_o=0x8000_0000, count_o=1; after dequeue, count_o=0.
- Fill 8 groups (pc 0x100, 0x110, …, 0x170) with deq_ready_i=0:
  - count_o=8, enq_ready_o=0.
  - A 9th enq with deq_ready_i=1 is rejected.
  - Drain in order 0x100…0x170, then refill 3 groups to exercise pointer wrap.
- Continuous enq + deq every cycle for 20 groups → count_o holds at 1, PCs come out in order with no bubbles after the first.
- Queue holding 5 groups; assert flush_i together with enq_valid_i=1 → deq_valid_o=0 that cycle; next cycle count_o=0, deq_valid_o=0, flushed enq is absent.
- enq with mask=4'b0000 → enq_ready_o handshake completes, count_o unchanged, nothing is dequeued.
- With IFU_FETCHQ_BYPASS_EN, empty queue, enq pc=0x200 with deq_ready_i=1 → same-cycle deq_valid_o=1, deq_pc_o=0x200, count_o stays 0. Without the macro → deq_valid_o=0 that cycle, 0x200 appears next cycle.

Source files
------------

// File: rtl/ifu_fetch_queue.sv
// ifu_fetch_queue: fetch-group FIFO between the IFU fetch/ICache output and decode.
// Each entry is one whole group: PC, instruction slots, slot mask, prediction.
// Optional feature macro: IFU_FETCHQ_BYPASS_EN
//   When defined, an empty queue forwards an offered (non-zero-mask) group
//   straight to the dequeue side in the same cycle.
module ifu_fetch_queue #(
    parameter int DEPTH           = 8,
    parameter int INSTR_PER_FETCH = 4,
    parameter int ILEN            = 32,
    parameter int XLEN            = 32
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              flush_i,
    input  logic                              enq_valid_i,
    output logic                              enq_ready_o,
    input  logic [XLEN-1:0]                   enq_pc_i,
    input  logic [INSTR_PER_FETCH*ILEN-1:0]   enq_instr_i,
    input  logic [INSTR_PER_FETCH-1:0]        enq_mask_i,
    input  logic                              enq_pred_taken_i,
    input  logic [XLEN-1:0]                   enq_pred_target_i,
    output logic                              deq_valid_o,
    input  logic                              deq_ready_i,
    output logic [XLEN-1:0]                   deq_pc_o,
    output logic [INSTR_PER_FETCH*ILEN-1:0]   deq_instr_o,
    output logic [INSTR_PER_FETCH-1:0]        deq_mask_o,
    output logic                              deq_pred_taken_o,
    output logic [XLEN-1:0]                   deq_pred_target_o,
    output logic [$clog2(DEPTH+1)-1:0]        count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int IW = INSTR_PER_FETCH * ILEN;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("ifu_fetch_queue: DEPTH must be a power of two and at least 2");
    end

    // Group storage (not reset; outputs are gated while nothing is valid)
    logic [XLEN-1:0]            r_mem_pc     [DEPTH];
    logic [IW-1:0]              r_mem_instr  [DEPTH];
    logic [INSTR_PER_FETCH-1:0] r_mem_mask   [DEPTH];
    logic                       r_mem_taken  [DEPTH];
    logic [XLEN-1:0]            r_mem_target [DEPTH];

    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_enq_fire;
    logic w_deq_fire;
    logic w_q_valid;
    logic w_bypass;
    logic w_write;
    logic w_read;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // Ready depends only on registered occupancy, never on deq_ready_i
    assign enq_ready_o = !w_full;
    assign count_o     = r_count;

    assign w_enq_fire = enq_valid_i & enq_ready_o & !flush_i;
    assign w_q_valid  = !w_empty & !flush_i;

`ifdef IFU_FETCHQ_BYPASS_EN
    assign w_bypass = w_empty & !flush_i & enq_valid_i & (|enq_mask_i);
`else
    assign w_bypass = 1'b0;
`endif

    assign deq_valid_o = w_q_valid | w_bypass;
    assign w_deq_fire  = deq_valid_o & deq_ready_i;

    // A bypassed group that decode takes immediately never touches storage;
    // zero-mask groups complete the handshake but are dropped.
    assign w_write = w_enq_fire & (|enq_mask_i) & !(w_bypass & deq_ready_i);
    assign w_read  = w_deq_fire & !w_empty;

    // Write the offered group into the tail slot
    always_ff @(posedge clk_i) begin
        if (w_write) begin
            r_mem_pc[r_wr_ptr]     <= enq_pc_i;
            r_mem_instr[r_wr_ptr]  <= enq_instr_i;
            r_mem_mask[r_wr_ptr]   <= enq_mask_i;
            r_mem_taken[r_wr_ptr]  <= enq_pred_taken_i;
            r_mem_target[r_wr_ptr] <= enq_pred_target_i;
        end
    end

    // Pointer and occupancy tracking; flush returns everything to the origin
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_write) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_read)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CW'(w_write) - CW'(w_read);
        end
    end

    // Head data mux: bypass source, storage head, or zero when nothing is valid
    always_comb begin
        deq_pc_o          = '0;
        deq_instr_o       = '0;
        deq_mask_o        = '0;
        deq_pred_taken_o  = 1'b0;
        deq_pred_target_o = '0;
        if (w_bypass) begin
            deq_pc_o          = enq_pc_i;
            deq_instr_o       = enq_instr_i;
            deq_mask_o        = enq_mask_i;
            deq_pred_taken_o  = enq_pred_taken_i;
            deq_pred_target_o = enq_pred_target_i;
        end else if (w_q_valid) begin
            deq_pc_o          = r_mem_pc[r_rd_ptr];
            deq_instr_o       = r_mem_instr[r_rd_ptr];
            deq_mask_o        = r_mem_mask[r_rd_ptr];
            deq_pred_taken_o  = r_mem_taken[r_rd_ptr];
            deq_pred_target_o = r_mem_target[r_rd_ptr];
        end
    end

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Self-checking bench for ifu_fetch_queue: directed scenarios plus random
// traffic checked against a queue-of-groups reference model.
module tb_ifu_fetch_queue;

    localparam int DEPTH = 8;
    localparam int IPF   = 4;
    localparam int ILEN  = 32;
    localparam int XLEN  = 32;
    localparam int CW    = $clog2(DEPTH+1);

`ifdef IFU_FETCHQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [XLEN-1:0]     pc;
        logic [IPF*ILEN-1:0] instr;
        logic [IPF-1:0]      mask;
        logic                taken;
        logic [XLEN-1:0]     target;
    } grp_t;

    localparam int VW = 2 + CW + $bits(grp_t);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic enq_valid = 1'b0;
    logic deq_ready = 1'b0;
    grp_t cur = '0;

    logic                enq_ready_o;
    logic                deq_valid_o;
    logic [XLEN-1:0]     deq_pc_o;
    logic [IPF*ILEN-1:0] deq_instr_o;
    logic [IPF-1:0]      deq_mask_o;
    logic                deq_pred_taken_o;
    logic [XLEN-1:0]     deq_pred_target_o;
    logic [CW-1:0]       count_o;

    grp_t mq[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ifu_fetch_queue #(.DEPTH(DEPTH), .INSTR_PER_FETCH(IPF), .ILEN(ILEN), .XLEN(XLEN)) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .flush_i           (flush),
        .enq_valid_i       (enq_valid),
        .enq_ready_o       (enq_ready_o),
        .enq_pc_i          (cur.pc),
        .enq_instr_i       (cur.instr),
        .enq_mask_i        (cur.mask),
        .enq_pred_taken_i  (cur.taken),
        .enq_pred_target_i (cur.target),
        .deq_valid_o       (deq_valid_o),
        .deq_ready_i       (deq_ready),
        .deq_pc_o          (deq_pc_o),
        .deq_instr_o       (deq_instr_o),
        .deq_mask_o        (deq_mask_o),
        .deq_pred_taken_o  (deq_pred_taken_o),
        .deq_pred_target_o (deq_pred_target_o),
        .count_o           (count_o)
    );

    function automatic grp_t mk(input logic [XLEN-1:0] pc, input logic [IPF-1:0] mask);
        grp_t g;
        g.pc     = pc;
        g.instr  = {$urandom(), $urandom(), $urandom(), $urandom()};
        g.mask   = mask;
        g.taken  = 1'($urandom_range(0, 1));
        g.target = $urandom();
        return g;
    endfunction

    // Reference model: what decode should see this cycle
    function automatic bit m_bypass();
        return BYP && mq.size() == 0 && !flush && enq_valid && cur.mask != '0;
    endfunction

    function automatic bit m_valid();
        return (mq.size() != 0 && !flush) || m_bypass();
    endfunction

    function automatic grp_t m_head();
        if (mq.size() != 0) return mq[0];
        if (m_bypass()) return cur;
        return '0;
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        return {mq.size() < DEPTH, m_valid(), CW'(mq.size()), m_valid() ? m_head() : grp_t'('0)};
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {enq_ready_o, deq_valid_o, count_o, deq_pc_o, deq_instr_o,
                deq_mask_o, deq_pred_taken_o, deq_pred_target_o};
    endfunction

    task automatic drive(input bit ev, input grp_t g, input bit dr, input bit fl);
        enq_valid = ev;
        cur       = g;
        deq_ready = dr;
        flush     = fl;
    endtask

    // Advance one clock and apply the queue rules to the model
    task automatic tick();
        int sz;
        bit byp;
        bit dv;
        @(posedge clk);
        sz  = mq.size();
        byp = m_bypass();
        dv  = m_valid();
        if (flush) begin
            mq.delete();
        end else begin
            if (dv && deq_ready && sz > 0) void'(mq.pop_front());
            if (enq_valid && sz < DEPTH && cur.mask != '0 && !(byp && deq_ready))
                mq.push_back(cur);
        end
        @(negedge clk);
    endtask

    task automatic drain();
        drive(1'b0, '0, 1'b1, 1'b0);
        repeat (DEPTH + 1) tick();
    endtask

    task automatic test_reset();
        drive(1'b0, '0, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({enq_ready_o, deq_valid_o, count_o} !== {1'b1, 1'b0, CW'(0)}) begin
            errors++;
            $display("FAIL reset_in got %b exp %b", {enq_ready_o, deq_valid_o, count_o}, {1'b1, 1'b0, CW'(0)});
        end
        checks++;
        if (obs_vec() !== {1'b1, 1'b0, CW'(0), grp_t'('0)}) begin
            errors++;
            $display("FAIL reset_data got %h exp %h", obs_vec(), {1'b1, 1'b0, CW'(0), grp_t'('0)});
        end
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        #1;
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_release got %h exp %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_basic();
        drive(1'b1, mk(32'h8000_0000, 4'hF), 1'b1, 1'b0);
        #1;
        checks++;
        if (deq_valid_o !== BYP) begin
            errors++;
            $display("FAIL basic_same_cycle got %b exp %b", deq_valid_o, BYP);
        end
        tick();
        drive(1'b0, '0, 1'b1, 1'b0);
        #1;
        checks++;
        if ({deq_valid_o, deq_pc_o, count_o} !== {~BYP, (BYP ? 32'h0 : 32'h8000_0000), (BYP ? CW'(0) : CW'(1))}) begin
            errors++;
            $display("FAIL basic_next_cycle got %h exp %h", {deq_valid_o, deq_pc_o, count_o},
                     {~BYP, (BYP ? 32'h0 : 32'h8000_0000), (BYP ? CW'(0) : CW'(1))});
        end
        tick();
        #1;
        checks++;
        if ({deq_valid_o, count_o} !== {1'b0, CW'(0)}) begin
            errors++;
            $display("FAIL basic_after_deq got %b exp %b", {deq_valid_o, count_o}, {1'b0, CW'(0)});
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, mk(XLEN'(32'h100 + i * 16), 4'hF), 1'b0, 1'b0);
            #1;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL fill_state got %h exp %h", obs_vec(), exp_vec());
            end
            tick();
        end
        // Ninth group offered while full, with decode taking the head
        drive(1'b1, mk(32'h180, 4'hF), 1'b1, 1'b0);
        #1;
        checks++;
        if ({count_o, enq_ready_o, deq_valid_o, deq_pc_o} !== {CW'(8), 1'b0, 1'b1, 32'h100}) begin
            errors++;
            $display("FAIL full_reject got %h exp %h", {count_o, enq_ready_o, deq_valid_o, deq_pc_o},
                     {CW'(8), 1'b0, 1'b1, 32'h100});
        end
        tick();
        for (int i = 1; i < DEPTH; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            #1;
            checks++;
            if ({deq_valid_o, deq_pc_o} !== {1'b1, XLEN'(32'h100 + i * 16)}) begin
                errors++;
                $display("FAIL drain_order got %h exp %h", {deq_valid_o, deq_pc_o}, {1'b1, XLEN'(32'h100 + i * 16)});
            end
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL drain_state got %h exp %h", obs_vec(), exp_vec());
            end
            tick();
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        #1;
        checks++;
        if ({deq_valid_o, count_o} !== {1'b0, CW'(0)}) begin
            errors++;
            $display("FAIL drain_empty got %b exp %b", {deq_valid_o, count_o}, {1'b0, CW'(0)});
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, mk(XLEN'(32'h300 + i * 16), 4'($urandom_range(1, 15))), 1'b0, 1'b0);
            #1;
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            #1;
            checks++;
            if (obs_vec() !== exp_vec() || deq_pc_o !== XLEN'(32'h300 + i * 16)) begin
                errors++;
                $display("FAIL wrap_state got %h exp %h", obs_vec(), exp_vec());
            end
            tick();
        end
    endtask

    task automatic test_stream();
        for (int c = 0; c <= 20; c++) begin
            drive(c < 20, mk(XLEN'(32'h1000 + c * 16), 4'hF), 1'b1, 1'b0);
            #1;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL stream_state got %h exp %h", obs_vec(), exp_vec());
            end
            checks++;
            if (count_o !== ((BYP || c == 0) ? CW'(0) : CW'(1))) begin
                errors++;
                $display("FAIL stream_count got %0d exp %0d", count_o, (BYP || c == 0) ? 0 : 1);
            end
            if (c >= int'(!BYP) && c < 20 + int'(!BYP)) begin
                checks++;
                if ({deq_valid_o, deq_pc_o} !== {1'b1, XLEN'(32'h1000 + (c - int'(!BYP)) * 16)}) begin
                    errors++;
                    $display("FAIL stream_order got %h exp %h", {deq_valid_o, deq_pc_o},
                             {1'b1, XLEN'(32'h1000 + (c - int'(!BYP)) * 16)});
                end
            end
            tick();
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, mk(XLEN'(32'h500 + i * 16), 4'hF), 1'b0, 1'b0);
            #1;
            tick();
        end
        drive(1'b1, mk(32'hDEAD0, 4'hF), 1'b1, 1'b1);
        #1;
        checks++;
        if ({deq_valid_o, enq_ready_o, count_o, deq_pc_o} !== {1'b0, 1'b1, CW'(5), 32'h0}) begin
            errors++;
            $display("FAIL flush_cycle got %h exp %h", {deq_valid_o, enq_ready_o, count_o, deq_pc_o},
                     {1'b0, 1'b1, CW'(5), 32'h0});
        end
        tick();
        drive(1'b0, '0, 1'b1, 1'b0);
        #1;
        checks++;
        if ({deq_valid_o, count_o} !== {1'b0, CW'(0)}) begin
            errors++;
            $display("FAIL flush_after got %b exp %b", {deq_valid_o, count_o}, {1'b0, CW'(0)});
        end
        tick();
        drive(1'b1, mk(32'h600, 4'h5), 1'b0, 1'b0);
        #1;
        tick();
        drive(1'b0, '0, 1'b1, 1'b0);
        #1;
        checks++;
        if (obs_vec() !== exp_vec() || deq_pc_o !== 32'h600) begin
            errors++;
            $display("FAIL flush_restart got %h exp %h", obs_vec(), exp_vec());
        end
        tick();
    endtask

    task automatic test_zero_mask();
        drive(1'b1, mk(32'h400, 4'h0), 1'b1, 1'b0);
        #1;
        checks++;
        if ({deq_valid_o, enq_ready_o} !== 2'b01) begin
            errors++;
            $display("FAIL zmask_empty got %b exp %b", {deq_valid_o, enq_ready_o}, 2'b01);
        end
        tick();
        drive(1'b0, '0, 1'b1, 1'b0);
        #1;
        checks++;
        if ({deq_valid_o, count_o} !== {1'b0, CW'(0)}) begin
            errors++;
            $display("FAIL zmask_dropped got %b exp %b", {deq_valid_o, count_o}, {1'b0, CW'(0)});
        end
        drive(1'b1, mk(32'h410, 4'h3), 1'b0, 1'b0);
        #1;
        tick();
        drive(1'b1, mk(32'h420, 4'h8), 1'b0, 1'b0);
        #1;
        tick();
        drive(1'b1, mk(32'h430, 4'h0), 1'b0, 1'b0);
        #1;
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            #1;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL zmask_drain got %h exp %h", obs_vec(), exp_vec());
            end
            tick();
        end
    endtask

    task automatic test_bypass();
        drain();
        drive(1'b1, mk(32'h200, 4'hF), 1'b1, 1'b0);
        #1;
        checks++;
        if ({deq_valid_o, deq_pc_o, count_o} !== {BYP, (BYP ? 32'h200 : 32'h0), CW'(0)}) begin
            errors++;
            $display("FAIL bypass_same got %h exp %h", {deq_valid_o, deq_pc_o, count_o},
                     {BYP, (BYP ? 32'h200 : 32'h0), CW'(0)});
        end
        tick();
        drive(1'b0, '0, 1'b1, 1'b0);
        #1;
        checks++;
        if ({deq_valid_o, deq_pc_o, count_o} !== {~BYP, (BYP ? 32'h0 : 32'h200), (BYP ? CW'(0) : CW'(1))}) begin
            errors++;
            $display("FAIL bypass_next got %h exp %h", {deq_valid_o, deq_pc_o, count_o},
                     {~BYP, (BYP ? 32'h0 : 32'h200), (BYP ? CW'(0) : CW'(1))});
        end
        tick();
        // Empty queue, decode stalled: group must be stored either way
        drive(1'b1, mk(32'h210, 4'h2), 1'b0, 1'b0);
        #1;
        tick();
        drive(1'b0, '0, 1'b1, 1'b0);
        #1;
        checks++;
        if ({deq_valid_o, deq_pc_o, count_o} !== {1'b1, 32'h210, CW'(1)}) begin
            errors++;
            $display("FAIL bypass_stall got %h exp %h", {deq_valid_o, deq_pc_o, count_o}, {1'b1, 32'h210, CW'(1)});
        end
        tick();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, mk(XLEN'(32'h700 + i * 16), 4'hF), 1'b0, 1'b0);
            #1;
            tick();
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs_vec() !== {1'b1, 1'b0, CW'(0), grp_t'('0)}) begin
            errors++;
            $display("FAIL async_reset got %h exp %h", obs_vec(), {1'b1, 1'b0, CW'(0), grp_t'('0)});
        end
        mq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 9) < 7,
                  mk($urandom(), ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15))),
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 24) == 0);
            #1;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random_state cycle %0d got %h exp %h", c, obs_vec(), exp_vec());
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill_drain();
        test_stream();
        test_flush();
        test_zero_mask();
        test_bypass();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
